// File: rtl/case_1_prod_accum_if.sv
// Block-level control, product input stream and frame-sum output stream of the
// product accumulator, bundled so the producer and write-back sides share one port.
interface case_1_prod_accum_if #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8
);
  logic                 ap_start;
  logic [LEN_WIDTH-1:0] len;
  logic                 ap_ready;
  logic                 ap_idle;
  logic                 ap_done;
  logic [DIN_WIDTH-1:0] din;
  logic                 din_vld;
  logic                 din_ack;
  logic [ACC_WIDTH-1:0] dout;
  logic                 dout_vld;
  logic                 dout_ack;
  logic                 ovf;

  modport master (
    output ap_start, len, din, din_vld, dout_ack,
    input  ap_ready, ap_idle, ap_done, din_ack, dout, dout_vld, ovf
  );

  modport slave (
    input  ap_start, len, din, din_vld, dout_ack,
    output ap_ready, ap_idle, ap_done, din_ack, dout, dout_vld, ovf
  );
endinterface

// File: rtl/case_1_prod_accum.sv
// Frame accumulator: sums 'len' signed products into a wider accumulator with
// optional saturation and hands the frame sum to write-back on a valid/ack port.
module case_1_prod_accum #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  case_1_prod_accum_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Returns {overflow, next accumulator}; the sum is formed one bit wider so the
  // overflow is visible as a disagreement between the top two bits.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [DIN_WIDTH-1:0] d
  );
    logic [ACC_WIDTH:0]   sum_v;
    logic                 ovf_v;
    logic [ACC_WIDTH-1:0] res_v;
    sum_v = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-DIN_WIDTH){d[DIN_WIDTH-1]}}, d};
    ovf_v = sum_v[ACC_WIDTH] ^ sum_v[ACC_WIDTH-1];
    if (ovf_v && SATURATE) begin
      res_v = sum_v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      res_v = sum_v[ACC_WIDTH-1:0];
    end
    return {ovf_v, res_v};
  endfunction

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] cnt_inc_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH:0]   add_s;
  logic                 ovf_r;
  logic [ACC_WIDTH-1:0] dout_r;
  logic                 dout_vld_r;
  logic                 ap_done_r;
  logic                 ap_idle_r;
  logic                 start_s;
  logic                 beat_s;
  logic                 last_s;

  assign start_s   = (state_r == ST_IDLE) && bus.ap_start;
  assign beat_s    = (state_r == ST_ACCUM) && bus.din_vld;
  assign cnt_inc_s = cnt_r + LEN_WIDTH'(1);
  assign last_s    = (cnt_inc_s == len_r);
  assign add_s     = acc_add(acc_r, bus.din);

  // Next-state decode of the IDLE/ACCUM/OUT control FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = (bus.len == LEN_WIDTH'(0)) ? ST_OUT : ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (beat_s && last_s) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_OUT: begin
        if (bus.dout_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs; status is derived from the
  // next state so it lines up with the state it describes.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r    <= ST_IDLE;
      len_r      <= {LEN_WIDTH{1'b0}};
      cnt_r      <= {LEN_WIDTH{1'b0}};
      acc_r      <= {ACC_WIDTH{1'b0}};
      ovf_r      <= 1'b0;
      dout_r     <= {ACC_WIDTH{1'b0}};
      dout_vld_r <= 1'b0;
      ap_done_r  <= 1'b0;
      ap_idle_r  <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      ap_idle_r  <= (state_nxt_s == ST_IDLE);
      dout_vld_r <= (state_nxt_s == ST_OUT);
      ap_done_r  <= (state_r == ST_OUT) && bus.dout_ack;
      if (start_s) begin
        len_r  <= bus.len;
        cnt_r  <= {LEN_WIDTH{1'b0}};
        acc_r  <= {ACC_WIDTH{1'b0}};
        ovf_r  <= 1'b0;
        dout_r <= {ACC_WIDTH{1'b0}};
      end else if (beat_s) begin
        acc_r <= add_s[ACC_WIDTH-1:0];
        cnt_r <= cnt_inc_s;
        ovf_r <= ovf_r | add_s[ACC_WIDTH];
        if (last_s) begin
          dout_r <= add_s[ACC_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.ap_ready = start_s;
  assign bus.din_ack  = (state_r == ST_ACCUM);
  assign bus.ap_idle  = ap_idle_r;
  assign bus.ap_done  = ap_done_r;
  assign bus.dout     = dout_r;
  assign bus.dout_vld = dout_vld_r;
  assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_case_1_prod_accum.sv
// Scoreboard bench: one 20-bit saturating accumulator and two 12-bit ones
// (saturating and wrapping) run in lockstep on the same stimulus.
module tb_case_1_prod_accum;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int d;
    bit o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   frame_vals[$];
  int   frame_gaps[$];

  case_1_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(20), .LEN_WIDTH(8)) if0 ();
  case_1_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(12), .LEN_WIDTH(8)) if1 ();
  case_1_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(12), .LEN_WIDTH(8)) if2 ();

  assign if1.ap_start = if0.ap_start;
  assign if1.len      = if0.len;
  assign if1.din      = if0.din;
  assign if1.din_vld  = if0.din_vld;
  assign if1.dout_ack = if0.dout_ack;
  assign if2.ap_start = if0.ap_start;
  assign if2.len      = if0.len;
  assign if2.din      = if0.din;
  assign if2.din_vld  = if0.din_vld;
  assign if2.dout_ack = if0.dout_ack;

  case_1_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(20), .LEN_WIDTH(8), .SATURATE(1'b1)) u_dut20 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if0));
  case_1_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(12), .LEN_WIDTH(8), .SATURATE(1'b1)) u_dut12s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if1));
  case_1_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(12), .LEN_WIDTH(8), .SATURATE(1'b0)) u_dut12w (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if2));

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame sum for a given accumulator width and overflow policy.
  function automatic exp_t model(input int w, input bit sat);
    longint acc;
    longint span;
    longint hi;
    longint lo;
    exp_t   r;
    acc  = 0;
    span = longint'(1) << w;
    hi   = span / 2 - 1;
    lo   = -(span / 2);
    r.o  = 1'b0;
    foreach (frame_vals[i]) begin
      acc += frame_vals[i];
      if (acc > hi || acc < lo) begin
        r.o = 1'b1;
        if (sat) acc = (acc > hi) ? hi : lo;
        else     acc = (acc > hi) ? acc - span : acc + span;
      end
    end
    r.d = int'(acc);
    return r;
  endfunction

  task automatic push_expected();
    q0.push_back(model(20, 1'b1));
    q1.push_back(model(12, 1'b1));
    q2.push_back(model(12, 1'b0));
  endtask

  // Output monitors: while valid, the held sum must match the scoreboard head.
  always @(negedge ap_clk) begin
    if (if0.dout_vld === 1'b1) begin
      if (q0.size() == 0) check_val("dout20_unexpected", q0.size(), 1);
      else begin
        check_val("dout20", $signed(if0.dout), q0[0].d);
        check_val("ovf20", if0.ovf, q0[0].o);
        check_val("din_ack_in_out", if0.din_ack, 0);
        if (if0.dout_ack === 1'b1) void'(q0.pop_front());
      end
    end
  end

  always @(negedge ap_clk) begin
    if (if1.dout_vld === 1'b1) begin
      if (q1.size() == 0) check_val("dout12s_unexpected", q1.size(), 1);
      else begin
        check_val("dout12s", $signed(if1.dout), q1[0].d);
        check_val("ovf12s", if1.ovf, q1[0].o);
        if (if1.dout_ack === 1'b1) void'(q1.pop_front());
      end
    end
  end

  always @(negedge ap_clk) begin
    if (if2.dout_vld === 1'b1) begin
      if (q2.size() == 0) check_val("dout12w_unexpected", q2.size(), 1);
      else begin
        check_val("dout12w", $signed(if2.dout), q2[0].d);
        check_val("ovf12w", if2.ovf, q2[0].o);
        if (if2.dout_ack === 1'b1) void'(q2.pop_front());
      end
    end
  end

  task automatic start_frame();
    if0.ap_start = 1'b1;
    if0.len      = 8'(frame_vals.size());
    @(negedge ap_clk);
    check_val("ap_ready", if0.ap_ready, 1);
    check_val("ap_idle_at_start", if0.ap_idle, 1);
    push_expected();
    @(posedge ap_clk); #1;
    if0.ap_start = 1'b0;
  endtask

  task automatic feed(input int d, input int gap);
    int t = 0;
    if0.din_vld = 1'b0;
    repeat (gap) begin @(posedge ap_clk); #1; end
    if0.din_vld = 1'b1;
    if0.din     = 10'(d);
    @(negedge ap_clk);
    while (if0.din_ack !== 1'b1 && t < 20) begin @(negedge ap_clk); t++; end
    check_val("din_ack_wait", t, 0);
    check_val("ap_idle_accum", if0.ap_idle, 0);
    @(posedge ap_clk); #1;
    if0.din_vld = 1'b0;
  endtask

  task automatic finish_frame(input int hold, input bit junk);
    int t = 0;
    @(negedge ap_clk);
    while (if0.dout_vld !== 1'b1 && t < 20) begin @(negedge ap_clk); t++; end
    check_val("dout_vld_latency", t, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge ap_clk); #1;
      if0.din_vld = junk;
      if0.din     = 10'(55);
      @(negedge ap_clk);
      check_val("dout_vld_hold", if0.dout_vld, 1);
    end
    @(posedge ap_clk); #1;
    if0.dout_ack = 1'b1;
    if0.din_vld  = 1'b0;
    @(negedge ap_clk);
    @(posedge ap_clk); #1;
    if0.dout_ack = 1'b0;
    @(negedge ap_clk);
    check_val("ap_done_pulse", if0.ap_done, 1);
    check_val("ap_idle_done", if0.ap_idle, 1);
    check_val("dout_vld_drop", if0.dout_vld, 0);
    @(posedge ap_clk); #1;
  endtask

  task automatic run_frame(input int hold, input bit junk);
    start_frame();
    foreach (frame_vals[i]) feed(frame_vals[i], frame_gaps[i]);
    finish_frame(hold, junk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dout"}, $signed(if0.dout), 0);
    check_val({tag, "_dout_vld"}, if0.dout_vld, 0);
    check_val({tag, "_din_ack"}, if0.din_ack, 0);
    check_val({tag, "_ap_ready"}, if0.ap_ready, 0);
    check_val({tag, "_ap_done"}, if0.ap_done, 0);
    check_val({tag, "_ap_idle"}, if0.ap_idle, 1);
    check_val({tag, "_ovf"}, if0.ovf, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ap_rst_n     = 1'b0;
    if0.ap_start = 1'b0;
    if0.len      = 8'd0;
    if0.din      = 10'd0;
    if0.din_vld  = 1'b0;
    if0.dout_ack = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_reset_outputs("reset");
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // Back-to-back beats, then a single-cycle done pulse.
    frame_vals = '{3, -5, 7, -1};
    frame_gaps = '{0, 0, 0, 0};
    run_frame(0, 1'b0);
    @(negedge ap_clk);
    check_val("ap_done_single", if0.ap_done, 0);
    @(posedge ap_clk); #1;

    // Gapped input, output held under back-pressure with din_vld asserted.
    frame_vals = '{-512, -512, 100};
    frame_gaps = '{0, 2, 0};
    run_frame(5, 1'b1);

    // Empty frame.
    frame_vals.delete();
    frame_gaps.delete();
    run_frame(0, 1'b0);

    // Positive overflow on the 12-bit instances.
    frame_vals.delete();
    frame_gaps.delete();
    repeat (8) begin frame_vals.push_back(511); frame_gaps.push_back(0); end
    run_frame(1, 1'b0);

    // Negative overflow on the 12-bit instances.
    frame_vals.delete();
    frame_gaps.delete();
    repeat (5) begin frame_vals.push_back(-512); frame_gaps.push_back(0); end
    run_frame(0, 1'b0);

    // Reset in the middle of a frame discards it.
    frame_vals = '{1, 2, 3, 4, 5};
    frame_gaps = '{0, 0, 0, 0, 0};
    start_frame();
    feed(1, 0);
    feed(2, 0);
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_reset_outputs("midrst");
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    frame_vals = '{1, 1};
    frame_gaps = '{0, 0};
    run_frame(0, 1'b0);

    // Continuous start: frames repeat every three cycles, len changes mid-frame ignored.
    frame_vals = '{7};
    if0.ap_start = 1'b1;
    if0.len      = 8'd1;
    if0.din      = 10'(7);
    if0.din_vld  = 1'b1;
    if0.dout_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      case (i % 3)
        0: begin
          check_val("cont_ready", if0.ap_ready, 1);
          check_val("cont_idle", if0.ap_idle, 1);
          if (i > 0) check_val("cont_done", if0.ap_done, 1);
          push_expected();
        end
        1: begin
          check_val("cont_ready_ignored", if0.ap_ready, 0);
          check_val("cont_din_ack", if0.din_ack, 1);
        end
        default: begin
          check_val("cont_dout_vld", if0.dout_vld, 1);
          check_val("cont_ready_out", if0.ap_ready, 0);
        end
      endcase
      @(posedge ap_clk); #1;
      if0.len = ((i % 3) == 2) ? 8'd1 : 8'd200;
    end
    if0.ap_start = 1'b0;
    if0.din_vld  = 1'b0;
    if0.dout_ack = 1'b0;
    @(negedge ap_clk);
    check_val("cont_last_done", if0.ap_done, 1);
    check_val("cont_last_ready", if0.ap_ready, 0);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    check_val("cont_stay_idle", if0.ap_idle, 1);
    check_val("cont_no_vld", if0.dout_vld, 0);

    check_val("q20_left", q0.size(), 0);
    check_val("q12s_left", q1.size(), 0);
    check_val("q12w_left", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
